// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared SHA-256 definitions. Holds the digest width, the
//                FIPS 180-4 initial hash words H0..H7 and the state type of
//                the digest transmitter FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int SHA256_DIGEST_W = 256;

    // Initial hash values. H0 occupies the least significant word of a digest.
    localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
    localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
    localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
    localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
    localparam logic [31:0] SHA256_H4 = 32'h510e527f;
    localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
    localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
    localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

    localparam logic [SHA256_DIGEST_W-1:0] SHA256_H_INIT = {
        SHA256_H7, SHA256_H6, SHA256_H5, SHA256_H4,
        SHA256_H3, SHA256_H2, SHA256_H1, SHA256_H0
    };

    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eSend = 1'b1
    } digest_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sha256_piso.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_piso
//  Description : Parallel-load, shift-out register. A load captures data_i;
//                each shift moves the next WORD_W slice into the output
//                position (low end when MSW_FIRST=0, high end otherwise).
//                Load has priority over shift.
//  Ports       : clk_i, reset_i (sync, active high), load_i, shift_i,
//                data_i [WIDTH], word_o [WORD_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_piso #(
    parameter int WIDTH     = 256,
    parameter int WORD_W    = 32,
    parameter bit MSW_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_shifted;

    // The single-word case has no slice to shift in, so it is handled apart
    // to keep every part-select in range.
    generate
        if (WORD_W == WIDTH) begin : g_single
            assign w_shifted = '0;
            assign word_o    = r_sr;
        end else if (MSW_FIRST) begin : g_msw
            assign w_shifted = {r_sr[WIDTH-WORD_W-1:0], {WORD_W{1'b0}}};
            assign word_o    = r_sr[WIDTH-1 -: WORD_W];
        end else begin : g_lsw
            assign w_shifted = {{WORD_W{1'b0}}, r_sr[WIDTH-1:WORD_W]};
            assign word_o    = r_sr[WORD_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sr <= '0;
        end else if (load_i) begin
            r_sr <= data_i;
        end else if (shift_i) begin
            r_sr <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha256_digest_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_digest_tx
//  Description : Retires 256-bit digests from the SHA-256 core (v/yumi) and
//                serializes each one as WORD_W-bit words on a valid/ready
//                link, flagging the final word. Counts digests sent
//                (saturating). Supports zero-bubble back-to-back digests.
//  Ports       : clk_i, reset_i (sync, active high), en_i,
//                v_i, digest_i [256], yumi_o        - core side
//                v_o, data_o [WORD_W], last_o, ready_i - outbound link
//                digest_cnt_o [16]                  - digests transmitted
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_digest_tx
    import sha256_pkg::*;
#(
    parameter int    WORD_W    = 32,
    parameter bit    MSW_FIRST = 1'b0,
    parameter string core_id   = "inv"
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic                       v_i,
    input  logic [SHA256_DIGEST_W-1:0] digest_i,
    output logic                       yumi_o,
    output logic                       v_o,
    output logic [WORD_W-1:0]          data_o,
    output logic                       last_o,
    input  logic                       ready_i,
    output logic [15:0]                digest_cnt_o
);

    localparam int NUM_WORDS = SHA256_DIGEST_W / WORD_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(NUM_WORDS - 1);

    generate
        if ((SHA256_DIGEST_W % WORD_W) != 0) begin : g_bad_word_w
            $error("sha256_digest_tx %s: WORD_W must divide 256", core_id);
        end
    endgenerate

    digest_tx_state_e  r_state;
    digest_tx_state_e  w_state_next;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [15:0]       r_digest_cnt;
    logic              w_active;
    logic              w_hs;
    logic              w_last;
    logic              w_yumi;
    logic              w_load;
    logic              w_shift;
    logic [WORD_W-1:0] w_word;

    // Outputs are suppressed while reset is applied so a digest interrupted
    // by reset emits nothing further.
    assign w_active = (r_state == eSend) && !reset_i;
    assign w_last   = (r_word_cnt == c_LAST_WORD);
    assign w_hs     = w_active && en_i && ready_i;

    always_comb begin
        w_state_next = r_state;
        w_yumi       = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        if (!reset_i) begin
            case (r_state)
                eIdle: begin
                    if (v_i && en_i) begin
                        w_yumi       = 1'b1;
                        w_load       = 1'b1;
                        w_state_next = eSend;
                    end
                end
                eSend: begin
                    if (w_hs) begin
                        w_shift = 1'b1;
                        if (w_last) begin
                            // Retire the next digest in the same cycle the
                            // current one finishes: no idle bubble.
                            if (v_i && en_i) begin
                                w_yumi = 1'b1;
                                w_load = 1'b1;
                            end else begin
                                w_state_next = eIdle;
                            end
                        end
                    end
                end
                default: w_state_next = eIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= eIdle;
            r_word_cnt   <= '0;
            r_digest_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load || (w_hs && w_last)) begin
                r_word_cnt <= '0;
            end else if (w_hs) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_hs && w_last && (r_digest_cnt != 16'hFFFF)) begin
                r_digest_cnt <= r_digest_cnt + 16'd1;
            end
        end
    end

    sha256_piso #(
        .WIDTH     (SHA256_DIGEST_W),
        .WORD_W    (WORD_W),
        .MSW_FIRST (MSW_FIRST)
    ) u_piso (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (w_load),
        .shift_i (w_shift),
        .data_i  (digest_i),
        .word_o  (w_word)
    );

    assign yumi_o       = w_yumi;
    assign v_o          = w_active && en_i;
    assign data_o       = w_active ? w_word : '0;
    assign last_o       = v_o && w_last;
    assign digest_cnt_o = r_digest_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_digest_tx
//  Description : Directed self-checking bench for sha256_digest_tx. Two
//                instances (LSW-first and MSW-first) share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_digest_tx;
    import sha256_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         en_i;
    logic         v_i;
    logic [255:0] digest_i;
    logic         ready_i;

    logic         yumi_l, v_l, last_l;
    logic [31:0]  data_l;
    logic [15:0]  cnt_l;
    logic         yumi_m, v_m, last_m;
    logic [31:0]  data_m;
    logic [15:0]  cnt_m;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sha256_digest_tx #(.WORD_W(32), .MSW_FIRST(1'b0), .core_id("lsw")) u_dut_l (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .v_i(v_i),
        .digest_i(digest_i), .yumi_o(yumi_l), .v_o(v_l), .data_o(data_l),
        .last_o(last_l), .ready_i(ready_i), .digest_cnt_o(cnt_l)
    );

    sha256_digest_tx #(.WORD_W(32), .MSW_FIRST(1'b1), .core_id("msw")) u_dut_m (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .v_i(v_i),
        .digest_i(digest_i), .yumi_o(yumi_m), .v_o(v_m), .data_o(data_m),
        .last_o(last_m), .ready_i(ready_i), .digest_cnt_o(cnt_m)
    );

    // "abc" digest words, H0 first, and the initial hash words.
    logic [31:0] a_w [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                             32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    logic [31:0] b_w [8];
    logic [255:0] dig_a;
    logic [255:0] dig_b;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int hs;
        b_w = '{SHA256_H0, SHA256_H1, SHA256_H2, SHA256_H3,
                SHA256_H4, SHA256_H5, SHA256_H6, SHA256_H7};
        dig_a = {a_w[7], a_w[6], a_w[5], a_w[4], a_w[3], a_w[2], a_w[1], a_w[0]};
        dig_b = SHA256_H_INIT;

        // ---------------- reset ----------------
        reset_i = 1'b1; en_i = 1'b1; v_i = 1'b1; digest_i = dig_a; ready_i = 1'b1;
        cyc(); cyc();
        #2;
        check("rst_yumi", yumi_l, 0);
        check("rst_v", v_l, 0);
        check("rst_data", data_l, 0);
        check("rst_last", last_l, 0);
        check("rst_cnt", cnt_l, 0);
        v_i = 1'b0; reset_i = 1'b0;
        cyc();
        #2;
        check("idle_v", v_l, 0);
        check("idle_data", data_l, 0);

        // ---------------- basic order, both word orders ----------------
        cyc();
        v_i = 1'b1; digest_i = dig_a;
        #2;
        check("t1_yumi", yumi_l, 1);
        check("t1_yumi_m", yumi_m, 1);
        cyc();
        v_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #2;
            check($sformatf("t1_v%0d", k), v_l, 1);
            check($sformatf("t1_word%0d", k), data_l, a_w[k]);
            check($sformatf("t1_last%0d", k), last_l, (k == 7));
            check($sformatf("t1_yumi%0d", k), yumi_l, 0);
            check($sformatf("t1_msw_word%0d", k), data_m, a_w[7-k]);
            check($sformatf("t1_msw_last%0d", k), last_m, (k == 7));
            cyc();
        end
        #2;
        check("t1_done_v", v_l, 0);
        check("t1_cnt", cnt_l, 1);
        check("t1_cnt_m", cnt_m, 1);

        // ---------------- backpressure 1,0,0,1 ----------------
        cyc();
        v_i = 1'b1; digest_i = dig_b;
        #2;
        check("t2_yumi", yumi_l, 1);
        cyc();
        v_i = 1'b0;
        hs = 0;
        for (int i = 0; i < 40 && hs < 8; i++) begin
            ready_i = ((i % 4) == 0) || ((i % 4) == 3);
            #2;
            check($sformatf("t2_v_c%0d", i), v_l, 1);
            check($sformatf("t2_word_c%0d", i), data_l, b_w[hs]);
            check($sformatf("t2_msw_word_c%0d", i), data_m, b_w[7-hs]);
            if (ready_i) begin
                check($sformatf("t2_last_c%0d", i), last_l, (hs == 7));
                hs++;
            end
            cyc();
        end
        ready_i = 1'b1;
        #2;
        check("t2_handshakes", hs, 8);
        check("t2_done_v", v_l, 0);
        check("t2_cnt", cnt_l, 2);

        // ---------------- back-to-back A then B ----------------
        cyc();
        v_i = 1'b1; digest_i = dig_a;
        #2;
        check("t3_yumi_a", yumi_l, 1);
        cyc();
        digest_i = dig_b;
        for (int k = 0; k < 16; k++) begin
            #2;
            check($sformatf("t3_v%0d", k), v_l, 1);
            check($sformatf("t3_word%0d", k), data_l, (k < 8) ? a_w[k] : b_w[k-8]);
            check($sformatf("t3_yumi%0d", k), yumi_l, (k == 7));
            check($sformatf("t3_last%0d", k), last_l, ((k % 8) == 7));
            cyc();
            if (k == 7) v_i = 1'b0;
        end
        #2;
        check("t3_done_v", v_l, 0);
        check("t3_cnt", cnt_l, 4);

        // ---------------- enable pause and idle gating ----------------
        cyc();
        v_i = 1'b1; digest_i = dig_a;
        #2;
        check("t4_yumi", yumi_l, 1);
        cyc();
        v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check($sformatf("t4_word%0d", k), data_l, a_w[k]);
            cyc();
        end
        en_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #2;
            check($sformatf("t4_pause_v%0d", j), v_l, 0);
            check($sformatf("t4_pause_last%0d", j), last_l, 0);
            cyc();
        end
        en_i = 1'b1;
        for (int k = 4; k < 8; k++) begin
            #2;
            check($sformatf("t4_resume_v%0d", k), v_l, 1);
            check($sformatf("t4_resume_word%0d", k), data_l, a_w[k]);
            check($sformatf("t4_resume_last%0d", k), last_l, (k == 7));
            cyc();
        end
        #2;
        check("t4_cnt", cnt_l, 5);
        v_i = 1'b1; en_i = 1'b0; digest_i = dig_b;
        #1;
        check("t4_idle_dis_yumi", yumi_l, 0);
        cyc();
        v_i = 1'b0; en_i = 1'b1;
        #2;
        check("t4_idle_stays", v_l, 0);

        // ---------------- reset mid-transmission ----------------
        cyc();
        v_i = 1'b1; digest_i = dig_b;
        #2;
        check("t5_yumi", yumi_l, 1);
        cyc();
        v_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            check($sformatf("t5_word%0d", k), data_l, b_w[k]);
            cyc();
        end
        #2;
        check("t5_word5", data_l, b_w[5]);
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        #2;
        check("t5_rst_v", v_l, 0);
        check("t5_rst_data", data_l, 0);
        check("t5_rst_cnt", cnt_l, 0);
        check("t5_rst_cnt_m", cnt_m, 0);
        cyc();
        #2;
        check("t5_idle_v", v_l, 0);
        v_i = 1'b1; digest_i = dig_a;
        #1;
        check("t5_new_yumi", yumi_l, 1);
        cyc();
        v_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #2;
            check($sformatf("t5_new_word%0d", k), data_l, a_w[k]);
            cyc();
        end
        #2;
        check("t5_new_cnt", cnt_l, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
